// File: rtl/mem_store_buffer.sv
// Posted-store buffer ahead of the data memory: queues stores, drains them in
// load-free cycles, and forwards the youngest matching buffered store to loads.
module mem_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              store_valid_i,
  input  logic [ADDR_W-1:0] store_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              store_ready_o,
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              buffer_empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  idx;

  assign store_ready_o  = (count_q != FULL_CNT);
  assign buffer_empty_o = (count_q == '0);
  assign fwd_hit_o      = fwd_hit_q;
  assign fwd_data_o     = fwd_data_q;
  assign push           = store_valid_i && store_ready_o;
  assign pop            = mem_write_o;

  // Loads own the memory port; the head entry drains only in load-free cycles.
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (load_valid_i) begin
      mem_read_o = 1'b1;
      mem_addr_o = load_addr_i;
    end else if (!buffer_empty_o) begin
      mem_write_o = 1'b1;
      mem_addr_o  = addr_q[head_q];
      mem_wdata_o = data_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = fwd_data_q;
    idx        = '0;
    if (load_valid_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = head_q + PTR_W'(k);
        if ((CNT_W'(k) < count_q) && (addr_q[idx] == load_addr_i)) begin
          fwd_hit_d  = 1'b1;
          fwd_data_d = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Entry payloads need no reset; validity comes from count/head.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= store_addr_i;
      data_q[tail_q] <= store_data_i;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based model with a 64-word memory.
module tb_mem_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  typedef struct {
    logic        sv;
    logic [5:0]  sa;
    logic [31:0] sd;
    logic        lv;
    logic [5:0]  la;
    logic        e_mr;
    logic        e_mw;
    logic [5:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_ready;
    logic        e_empty;
    logic        e_hit;
    logic        chk_load;
    logic [31:0] e_load;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              store_valid;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic              store_ready;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              buffer_empty;

  mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .store_valid_i (store_valid),
    .store_addr_i  (store_addr),
    .store_data_i  (store_data),
    .store_ready_o (store_ready),
    .load_valid_i  (load_valid),
    .load_addr_i   (load_addr),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .fwd_hit_o     (fwd_hit),
    .fwd_data_o    (fwd_data),
    .buffer_empty_o(buffer_empty)
  );

  always #5 clk = ~clk;

  // Data memory: write commits on negedge, read data registered on posedge.
  logic [31:0] mem [64];
  logic [31:0] rdata;
  always @(negedge clk) if (mem_write) mem[mem_addr] = mem_wdata;
  always @(posedge clk) if (mem_read) rdata <= mem[mem_addr];

  // Reference model state.
  ent_t        q[$];
  logic [31:0] ref_mem [64];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sv, input logic [5:0] sa, input logic [31:0] sd,
                              input logic lv, input logic [5:0] la,
                              input logic e_mr, input logic e_mw, input logic [5:0] e_addr,
                              input logic [31:0] e_wd, input logic e_ready, input logic e_empty,
                              input logic e_hit, input logic chk_load, input logic [31:0] e_load);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
    v.e_mr = e_mr; v.e_mw = e_mw; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_ready = e_ready; v.e_empty = e_empty; v.e_hit = e_hit;
    v.chk_load = chk_load; v.e_load = e_load;
    return v;
  endfunction

  // One clock cycle: drive at posedge+1, check port select at negedge, check loads after posedge.
  task automatic step(input logic sv, input logic [5:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [5:0] la, input bit use_tab, input vec_t v);
    int          sz;
    logic        e_hit;
    logic [31:0] e_val;
    ent_t        h;
    store_valid = sv;
    store_addr  = sa;
    store_data  = sd;
    load_valid  = lv;
    load_addr   = la;
    @(negedge clk);
    sz = q.size();
    check("store_ready", 32'(store_ready), 32'(sz < DEPTH));
    check("buffer_empty", 32'(buffer_empty), 32'(sz == 0));
    check("mem_read", 32'(mem_read), 32'(lv));
    check("mem_write", 32'(mem_write), 32'(!lv && sz > 0));
    if (lv) begin
      check("mem_addr_load", 32'(mem_addr), 32'(la));
    end else if (sz > 0) begin
      check("drain_addr", 32'(mem_addr), 32'(q[0].a));
      check("drain_data", mem_wdata, q[0].d);
    end else begin
      check("idle_addr", 32'(mem_addr), 32'd0);
      check("idle_wdata", mem_wdata, 32'd0);
    end
    if (use_tab) begin
      check("tab_mem_read", 32'(mem_read), 32'(v.e_mr));
      check("tab_mem_write", 32'(mem_write), 32'(v.e_mw));
      check("tab_mem_addr", 32'(mem_addr), 32'(v.e_addr));
      if (!v.e_mr) check("tab_wdata", mem_wdata, v.e_wd);
      check("tab_ready", 32'(store_ready), 32'(v.e_ready));
      check("tab_empty", 32'(buffer_empty), 32'(v.e_empty));
    end
    e_hit = 1'b0;
    e_val = ref_mem[la];
    if (lv) begin
      for (int i = 0; i < sz; i++) begin
        if (q[i].a == la) begin
          e_hit = 1'b1;
          e_val = q[i].d;
        end
      end
    end
    if (!lv && sz > 0) begin
      h = q.pop_front();
      ref_mem[h.a] = h.d;
    end
    if (sv && sz < DEPTH) begin
      h.a = sa;
      h.d = sd;
      q.push_back(h);
    end
    @(posedge clk);
    #1;
    check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    if (lv) check("load_value", fwd_hit ? fwd_data : rdata, e_val);
    if (use_tab) begin
      check("tab_fwd_hit", 32'(fwd_hit), 32'(v.e_hit));
      if (v.chk_load) check("tab_load_value", fwd_hit ? fwd_data : rdata, v.e_load);
    end
  endtask

  initial begin
    vec_t tab [10];
    vec_t none;
    int   pct;

    none = mk(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Drain, forward-youngest and simultaneous load/store scenarios from an empty buffer.
    tab[0] = mk(1'b1, 6'd5, 32'hA5A5A5A5, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tab[1] = mk(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tab[2] = mk(1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5);
    tab[3] = mk(1'b1, 6'd9, 32'h11, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tab[4] = mk(1'b1, 6'd9, 32'h22, 1'b0, 6'd0, 1'b0, 1'b1, 6'd9, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tab[5] = mk(1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 1'b1, 1'b0, 6'd9, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22);
    tab[6] = mk(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd9, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tab[7] = mk(1'b1, 6'd3, 32'h77, 1'b1, 6'd3, 1'b1, 1'b0, 6'd3, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    tab[8] = mk(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd3, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tab[9] = mk(1'b0, 6'd0, 32'h0, 1'b1, 6'd3, 1'b1, 1'b0, 6'd3, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77);

    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1;
    store_valid = 1'b0; store_addr = '0; store_data = '0;
    load_valid = 1'b0; load_addr = '0;
    #1;
    check("rst_ready", 32'(store_ready), 32'd1);
    check("rst_empty", 32'(buffer_empty), 32'd1);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      step(tab[i].sv, tab[i].sa, tab[i].sd, tab[i].lv, tab[i].la, 1'b1, tab[i]);

    // Full: fill while a load holds the port, drop a fifth store, then drain in order.
    for (int i = 0; i < 4; i++)
      step(1'b1, 6'(10 + i), 32'hF000 + 32'(i), 1'b1, 6'd63, 1'b0, none);
    check("full_ready_low", 32'(store_ready), 32'd0);
    step(1'b1, 6'd14, 32'hDEAD, 1'b1, 6'd63, 1'b0, none);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, none);
      if (i == 0) check("ready_after_first_pop", 32'(store_ready), 32'd1);
      check("full_drain_target", ref_mem[6'(10 + i)], 32'hF000 + 32'(i));
    end
    check("dropped_store", ref_mem[14], 32'h0);
    step(1'b0, 6'd0, 32'h0, 1'b1, 6'd14, 1'b0, none);

    // Wrap: push every cycle while draining so the pointers run past DEPTH.
    for (int i = 0; i < 6; i++)
      step(1'b1, 6'(32 + i), 32'hC0DE0000 + 32'(i), 1'b0, 6'd0, 1'b0, none);
    step(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, none);
    for (int i = 0; i < 6; i++)
      step(1'b0, 6'd0, 32'h0, 1'b1, 6'(32 + i), 1'b0, none);

    // Reset mid-drain with three buffered entries and FwdHit set.
    for (int i = 0; i < 3; i++)
      step(1'b1, 6'(20 + i), 32'hBEEF0000 + 32'(i), 1'b1, 6'd63, 1'b0, none);
    step(1'b0, 6'd0, 32'h0, 1'b1, 6'd21, 1'b0, none);
    store_valid = 1'b0;
    load_valid  = 1'b0;
    #2;
    check("pre_rst_mem_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_write", 32'(mem_write), 32'd0);
    check("mid_rst_empty", 32'(buffer_empty), 32'd1);
    check("mid_rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("mid_rst_ready", 32'(store_ready), 32'd1);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    step(1'b0, 6'd0, 32'h0, 1'b1, 6'd20, 1'b0, none);

    // Randomized traffic: load-heavy phase fills the buffer, drain-heavy phase empties it.
    for (int n = 0; n < 400; n++) begin
      pct = (n < 200) ? 70 : 30;
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 99) < pct), 6'($urandom_range(0, 7)), 1'b0, none);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
